rtc_trigger: RTL and testbench
==============================

RTC_TRIGGER -- requirements
Module: rtc_trigger

Interface
REQ-001 SHALL have parameter time_acc_modulo, default 38'd256000000000, meaning the ns accumulator wrap value (ns<<8); ns wraps at time_acc_modulo/256.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port time_reg_ns, input, 38, RTC ns[37:8] plus fraction[7:0].
REQ-005 SHALL have port time_reg_sec, input, 48, RTC seconds.
REQ-006 SHALL have port trig_ld, input, 1, one-cycle strobe that loads the target and arms.
REQ-007 SHALL have port trig_sec_in, input, 48, target seconds.
REQ-008 SHALL have port trig_ns_in, input, 30, target ns (integer).
REQ-009 SHALL have port trig_width_in, input, 32, pulse width in clk cycles.
REQ-010 SHALL have port trig_period_in, input, 30, periodic interval in ns, where 0 means one-shot.
REQ-011 SHALL have port trig_cancel, input, 1, disarms the block.
REQ-012 SHALL have port trig_out, output, 1, trigger pulse.
REQ-013 SHALL have port trig_armed, output, 1, high in ARMED.
REQ-014 SHALL have port trig_missed, output, 1, one-cycle late-target pulse.
REQ-015 SHALL have port trig_done, output, 1, one-cycle pulse on the last trig_out cycle.

Function
REQ-016 SHALL implement states IDLE, ARMED, PULSE.
REQ-017 SHALL capture target, width and period on trig_ld.
- Width 0 SHALL be treated as 1.
- Loaded trig_ns_in >= modulo/256 SHALL be clamped to modulo/256-1.
REQ-018 SHALL compare {time_reg_sec, time_reg_ns[37:8]} >= {target_sec, target_ns}, unsigned, ignoring fraction, via a registered compare.
- trig_out SHALL rise on the edge after the first clk sample where the compare holds.
REQ-019 SHALL treat the first ARMED cycle as late-check: if the compare already holds, trig_missed pulses one cycle.
- One-shot: SHALL go to IDLE with trig_out never asserted.
- Periodic: target SHALL advance by period and the block SHALL stay ARMED.
REQ-020 SHALL, on a normal fire, go ARMED->PULSE with trig_armed low and trig_out high for exactly width cycles.
- trig_done SHALL be high in the final cycle.
- Then IDLE for one-shot, or ARMED with the target advanced by period.
REQ-021 SHALL compute target advance as ns+period.
- If the result >= modulo/256: subtract modulo/256 and increment sec; sec SHALL wrap modulo 2^48.
- Advance SHALL complete in the fire cycle.
REQ-022 SHALL treat trig_ld in any state as immediately re-arming (ARMED, late-check applies).
- If in PULSE, trig_out SHALL drop at the next edge with no trig_done.
REQ-023 SHALL make trig_cancel force IDLE and trig_out low at the next edge.
- trig_ld with trig_cancel in the same cycle: trig_ld SHALL win.
REQ-024 SHALL fire on the true compare only: a backward RTC time jump while ARMED delays the fire, and a forward jump fires immediately (not missed).

Reset
REQ-025 SHALL, on rst, drive state IDLE, all outputs 0, and target/width/period registers 0, asynchronously.
- A rst during PULSE SHALL drop trig_out without trig_done.

Configuration
REQ-026 With RTC_TRIG_PERIODIC_EN defined, SHALL implement periodic re-arm per REQ-019/020/021.
- Undefined: trig_period_in SHALL be ignored, behaviour always one-shot, and the adder logic removed.

Structure
REQ-027 SHALL place the state enum, RTC_NS_W=30, RTC_SEC_W=48 and RTC_FRAC_W=8 in shared package rtc_trig_pkg.
REQ-028 SHALL implement the sec/ns modulo adder as sub-module rtc_time_add, reusable by the other RTC blocks.

Verification (time_acc_modulo=256000, i.e. ns wraps at 1000, RTC +8 ns/clk)
REQ-029 SHALL cover: assert rst mid-run -> all outputs 0 and IDLE next sample; release -> nothing fires without trig_ld.
REQ-030 SHALL cover: RTC at 10.900, load target 11.000, width 4 -> trig_out high 4 cycles starting the edge after RTC reads 11.004; trig_done on the 4th cycle; IDLE after.
REQ-031 SHALL cover: RTC at 10.900, load target 10.100 -> trig_missed one cycle, trig_out stays 0, trig_armed 0 after.
REQ-032 SHALL cover (macro on): target 11.000, period 200, width 2 -> pulses at 11.000, 11.200, 11.400, 11.600, 11.800, 12.000 (carry verified).
REQ-033 SHALL cover: trig_cancel on the 2nd PULSE cycle -> trig_out low next edge, no trig_done; trig_ld with trig_cancel in the same cycle -> ARMED.
REQ-034 SHALL cover (macro off): repeat REQ-032 stimulus -> single pulse at 11.000, then IDLE.

Source files
------------

// File: rtl/rtc_trig_pkg.sv
// rtc_trig_pkg
// Shared definitions for the RTC trigger family: RTC field widths, the
// trigger FSM state encoding and a helper that clamps a loaded ns value
// into the valid range of the ns counter.
package rtc_trig_pkg;

  localparam int RTC_NS_W   = 30;
  localparam int RTC_SEC_W  = 48;
  localparam int RTC_FRAC_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PULSE = 2'd2
  } trig_state_e;

  // A loaded ns value at or above the wrap point can never be reached by
  // the RTC, so pin it to the last representable ns of the second.
  function automatic logic [RTC_NS_W-1:0] clamp_ns(
    input logic [RTC_NS_W-1:0] ns,
    input logic [RTC_NS_W-1:0] ns_mod
  );
    return (ns >= ns_mod) ? (ns_mod - RTC_NS_W'(1)) : ns;
  endfunction

endpackage

// File: rtl/rtc_time_add.sv
// rtc_time_add
// Combinational sec/ns adder: {sec_out, ns_out} = {sec_in, ns_in} + add_ns,
// with ns wrapping at NS_MOD and carrying into seconds. Seconds wrap
// modulo 2^RTC_SEC_W. A single wrap step is applied, so add_ns is expected
// to be below NS_MOD.
// Ports:
//   sec_in  [47:0] base seconds
//   ns_in   [29:0] base ns (integer)
//   add_ns  [29:0] ns increment
//   sec_out [47:0] result seconds
//   ns_out  [29:0] result ns
module rtc_time_add
  import rtc_trig_pkg::*;
#(
  parameter logic [RTC_NS_W-1:0] NS_MOD = 30'd1000000000
) (
  input  logic [RTC_SEC_W-1:0] sec_in,
  input  logic [RTC_NS_W-1:0]  ns_in,
  input  logic [RTC_NS_W-1:0]  add_ns,
  output logic [RTC_SEC_W-1:0] sec_out,
  output logic [RTC_NS_W-1:0]  ns_out
);

  logic [RTC_NS_W:0] sum;

  always_comb begin
    sum = {1'b0, ns_in} + {1'b0, add_ns};
    if (sum >= {1'b0, NS_MOD}) begin
      ns_out  = RTC_NS_W'(sum - {1'b0, NS_MOD});
      sec_out = sec_in + RTC_SEC_W'(1);
    end else begin
      ns_out  = sum[RTC_NS_W-1:0];
      sec_out = sec_in;
    end
  end

endmodule

// File: rtl/rtc_trigger.sv
// rtc_trigger
// Fires a pulse of programmable width when the RTC reaches a loaded
// {sec, ns} target. A target already in the past on arming is reported
// through trig_missed instead of firing.
// Optional feature: define RTC_TRIG_PERIODIC_EN to enable periodic re-arm
// (target advanced by trig_period_in after every fire or miss; period 0
// stays one-shot). Without it the block is always one-shot.
// Ports:
//   rst            async active-high reset
//   clk            clock
//   time_reg_ns    RTC ns[37:8] + fraction[7:0]
//   time_reg_sec   RTC seconds
//   trig_ld        load target/width/period and arm
//   trig_sec_in    target seconds
//   trig_ns_in     target ns
//   trig_width_in  pulse width in clk cycles (0 treated as 1)
//   trig_period_in re-arm interval in ns (0 = one-shot)
//   trig_cancel    disarm (trig_ld wins when both are high)
//   trig_out       trigger pulse
//   trig_armed     high while waiting for the target
//   trig_missed    one-cycle pulse when armed with a target already passed
//   trig_done      high on the last trig_out cycle of a complete pulse
module rtc_trigger
  import rtc_trig_pkg::*;
#(
  parameter logic [37:0] time_acc_modulo = 38'd256000000000
) (
  input  logic        rst,
  input  logic        clk,
  input  logic [37:0] time_reg_ns,
  input  logic [47:0] time_reg_sec,
  input  logic        trig_ld,
  input  logic [47:0] trig_sec_in,
  input  logic [29:0] trig_ns_in,
  input  logic [31:0] trig_width_in,
  input  logic [29:0] trig_period_in,
  input  logic        trig_cancel,
  output logic        trig_out,
  output logic        trig_armed,
  output logic        trig_missed,
  output logic        trig_done
);

  localparam logic [RTC_NS_W-1:0] NS_MOD =
    time_acc_modulo[RTC_NS_W+RTC_FRAC_W-1:RTC_FRAC_W];

  trig_state_e          state_q, state_d;
  logic                 first_q, first_d;   // next ARMED cycle is the late-check
  logic                 cmp_q, cmp_d;       // RTC >= target, registered
  logic [31:0]          cnt_q, cnt_d;       // remaining pulse cycles
  logic [31:0]          width_q, width_d;
  logic [RTC_SEC_W-1:0] tsec_q, tsec_d;
  logic [RTC_NS_W-1:0]  tns_q, tns_d;

  logic                 periodic;
  logic [RTC_SEC_W-1:0] adv_sec;
  logic [RTC_NS_W-1:0]  adv_ns;
  logic                 unused_frac;

  assign unused_frac = ^time_reg_ns[RTC_FRAC_W-1:0];

`ifdef RTC_TRIG_PERIODIC_EN
  logic [RTC_NS_W-1:0] period_q, period_d;

  rtc_time_add #(
    .NS_MOD (NS_MOD)
  ) u_time_add (
    .sec_in  (tsec_q),
    .ns_in   (tns_q),
    .add_ns  (period_q),
    .sec_out (adv_sec),
    .ns_out  (adv_ns)
  );

  assign periodic = (period_q != '0);
`else
  logic unused_period;

  assign unused_period = ^trig_period_in;
  assign periodic      = 1'b0;
  assign adv_sec       = tsec_q;
  assign adv_ns        = tns_q;
`endif

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    tsec_d  = tsec_q;
    tns_d   = tns_q;
`ifdef RTC_TRIG_PERIODIC_EN
    period_d = period_q;
`endif

    unique case (state_q)
      ST_ARMED: begin
        if (cmp_q) begin
          // Both a fire and a periodic miss move the target on by one period.
          if (periodic) begin
            tsec_d = adv_sec;
            tns_d  = adv_ns;
          end
          if (!first_q) begin
            state_d = ST_PULSE;
            cnt_d   = width_q;
          end else if (!periodic) begin
            state_d = ST_IDLE;
          end
          // A periodic miss keeps first set: the advanced target is
          // late-checked again on the next cycle.
        end else begin
          first_d = 1'b0;
        end
      end
      ST_PULSE: begin
        if (cnt_q == 32'd1) begin
          state_d = periodic ? ST_ARMED : ST_IDLE;
          first_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: ;
    endcase

    if (trig_cancel) begin
      state_d = ST_IDLE;
    end

    if (trig_ld) begin
      state_d = ST_ARMED;
      first_d = 1'b1;
      tsec_d  = trig_sec_in;
      tns_d   = clamp_ns(trig_ns_in, NS_MOD);
      width_d = (trig_width_in == 32'd0) ? 32'd1 : trig_width_in;
`ifdef RTC_TRIG_PERIODIC_EN
      period_d = trig_period_in;
`endif
    end

    // Compare against the next target so cmp_q always matches target_q,
    // including the first cycle after a load or an advance.
    cmp_d = {time_reg_sec, time_reg_ns[37:RTC_FRAC_W]} >= {tsec_d, tns_d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      first_q <= 1'b0;
      cmp_q   <= 1'b0;
      cnt_q   <= '0;
      width_q <= '0;
      tsec_q  <= '0;
      tns_q   <= '0;
`ifdef RTC_TRIG_PERIODIC_EN
      period_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      cmp_q   <= cmp_d;
      cnt_q   <= cnt_d;
      width_q <= width_d;
      tsec_q  <= tsec_d;
      tns_q   <= tns_d;
`ifdef RTC_TRIG_PERIODIC_EN
      period_q <= period_d;
`endif
    end
  end

  assign trig_out    = (state_q == ST_PULSE);
  assign trig_armed  = (state_q == ST_ARMED);
  assign trig_missed = trig_armed && first_q && cmp_q;
  assign trig_done   = trig_out && (cnt_q == 32'd1);

endmodule

// File: tb/tb_rtc_trigger.sv
// tb_rtc_trigger
// Randomized and directed stimulus for rtc_trigger with ns wrapping at 1000
// and the RTC advancing 8 ns per clock. Expected pulse/miss events are
// derived from target arithmetic and pushed into a queue; a monitor pops
// and compares them as the DUT produces pulses and misses.
module tb_rtc_trigger;

  localparam logic [37:0] MODULO  = 38'd256000;
  localparam longint      NS_WRAP = 1000;
`ifdef RTC_TRIG_PERIODIC_EN
  localparam bit PERIODIC = 1'b1;
`else
  localparam bit PERIODIC = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [37:0] time_reg_ns;
  logic [47:0] time_reg_sec;
  logic        trig_ld;
  logic [47:0] trig_sec_in;
  logic [29:0] trig_ns_in;
  logic [31:0] trig_width_in;
  logic [29:0] trig_period_in;
  logic        trig_cancel;
  logic        trig_out;
  logic        trig_armed;
  logic        trig_missed;
  logic        trig_done;

  rtc_trigger #(
    .time_acc_modulo (MODULO)
  ) dut (
    .rst            (rst),
    .clk            (clk),
    .time_reg_ns    (time_reg_ns),
    .time_reg_sec   (time_reg_sec),
    .trig_ld        (trig_ld),
    .trig_sec_in    (trig_sec_in),
    .trig_ns_in     (trig_ns_in),
    .trig_width_in  (trig_width_in),
    .trig_period_in (trig_period_in),
    .trig_cancel    (trig_cancel),
    .trig_out       (trig_out),
    .trig_armed     (trig_armed),
    .trig_missed    (trig_missed),
    .trig_done      (trig_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit     is_miss;
    longint rtc;   // RTC (total ns) shown on the first observed cycle
    int     len;
    bit     done;
  } ev_t;

  ev_t    exp_q[$];
  int     total = 0;
  int     bad   = 0;
  longint rtc_cur = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: {out,armed,missed,done} got %b expected %b", name, act, expv);
    end else begin
      $display("ok   %s: {out,armed,missed,done}=%b", name, act);
    end
  endtask

  // One clock cycle of stimulus, applied at the falling edge.
  task automatic drive(input longint t, input logic ld, input logic cancel);
    @(negedge clk);
    rtc_cur      = t;
    time_reg_sec = 48'(t / NS_WRAP);
    time_reg_ns  = {30'(t % NS_WRAP), 8'($urandom_range(0, 255))};
    trig_ld      = ld;
    trig_cancel  = cancel;
  endtask

  // Expected events for a run armed at sample 0 (RTC r0, +8 ns per sample)
  // and stopped (cancel or reset) at sample s_stop. An arming sample whose
  // RTC already meets the target is a miss; otherwise the first later
  // sample meeting it fires, and the pulse is seen from the sample after
  // that for w samples. Periodic targets move on by per after each event.
  task automatic model(input longint r0, input longint tgt, input int w,
                       input longint per, input int s_stop);
    longint t = tgt;
    int     a = 0;
    int     j;
    ev_t    e;
    while (a < s_stop) begin
      if (r0 + 8 * a >= t) begin
        e.is_miss = 1'b1; e.rtc = r0 + 8 * a; e.len = 0; e.done = 1'b0;
        exp_q.push_back(e);
        if (per == 0) break;
        t += per;
        a++;
      end else begin
        j = a + 1;
        while ((r0 + 8 * j < t) && (j < s_stop)) j++;
        if (j + 1 >= s_stop) break;
        e.is_miss = 1'b0;
        e.rtc     = r0 + 8 * (j + 1);
        e.len     = (w < s_stop - 1 - j) ? w : (s_stop - 1 - j);
        e.done    = (j + w <= s_stop - 1);
        exp_q.push_back(e);
        if (per == 0 || !e.done) break;
        t += per;
        a = j + w + 1;
      end
    end
  endtask

  task automatic scenario(input string name, input longint r0, input longint tsec,
                          input int tns_in, input int w_in, input int per_in,
                          input int s_stop, input bit use_rst);
    longint tgt;
    int     w;
    tgt = tsec * NS_WRAP + ((tns_in >= NS_WRAP) ? (NS_WRAP - 1) : longint'(tns_in));
    w   = (w_in == 0) ? 1 : w_in;
    model(r0, tgt, w, PERIODIC ? longint'(per_in) : 0, s_stop);
    $display("run  %s: rtc=%0d target=%0d width=%0d period=%0d stop=%0d rst=%0d",
             name, r0, tgt, w_in, per_in, s_stop, use_rst);
    trig_sec_in    = 48'(tsec);
    trig_ns_in     = 30'(tns_in);
    trig_width_in  = 32'(w_in);
    trig_period_in = 30'(per_in);
    drive(r0, 1'b1, 1'b0);
    for (int k = 1; k < s_stop; k++) drive(r0 + 8 * k, 1'b0, 1'b0);
    drive(r0 + 8 * s_stop, 1'b0, !use_rst);
    if (use_rst) rst = 1'b1;
    @(posedge clk);
    #3;
    check({name, "_stop"}, {trig_out, trig_armed, trig_missed, trig_done}, 4'b0000);
    drive(r0 + 8 * (s_stop + 1), 1'b0, 1'b0);
    rst = 1'b0;
    // Idle tail: with nothing loaded, the monitor must see no event.
    for (int k = 2; k < (use_rst ? 30 : 6); k++) drive(r0 + 8 * (s_stop + k), 1'b0, 1'b0);
  endtask

  // Monitor: turns DUT outputs into pulse/miss events and scores them.
  initial begin : monitor
    bit     in_p;
    longint st;
    int     len;
    int     dcnt;
    int     done_at;
    bit     armed_bad;
    int     got_done;
    ev_t    e;
    in_p = 1'b0; st = 0; len = 0; dcnt = 0; done_at = 0; armed_bad = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (trig_out) begin
        if (!in_p) begin
          in_p = 1'b1; st = rtc_cur; len = 0; dcnt = 0; done_at = 0; armed_bad = 1'b0;
        end
        len++;
        if (trig_done) begin dcnt++; done_at = len; end
        if (trig_armed) armed_bad = 1'b1;
      end else begin
        if (trig_done) begin
          total++; bad++;
          $display("FAIL done_stray: trig_done=1 with trig_out=0 at rtc=%0d, required 0", rtc_cur);
        end
        if (in_p) begin
          in_p = 1'b0;
          got_done = (dcnt == 0) ? 0 : ((dcnt == 1 && done_at == len) ? 1 : 2);
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL pulse_unexpected: pulse at rtc=%0d len=%0d, required none", st, len);
          end else begin
            e = exp_q.pop_front();
            if (e.is_miss || e.rtc != st || e.len != len || got_done != int'(e.done) || armed_bad) begin
              bad++;
              $display("FAIL pulse: got rtc=%0d len=%0d done=%0d armed_in_pulse=%0d, required %s rtc=%0d len=%0d done=%0d",
                       st, len, got_done, armed_bad, e.is_miss ? "miss" : "pulse", e.rtc, e.len, e.done);
            end else begin
              $display("ok   pulse: rtc=%0d len=%0d done=%0d", st, len, got_done);
            end
          end
        end
      end
      if (trig_missed) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL miss_unexpected: miss at rtc=%0d, required none", rtc_cur);
        end else begin
          e = exp_q.pop_front();
          if (!e.is_miss || e.rtc != rtc_cur || trig_out) begin
            bad++;
            $display("FAIL miss: got miss at rtc=%0d out=%0d, required %s at rtc=%0d",
                     rtc_cur, trig_out, e.is_miss ? "miss" : "pulse", e.rtc);
          end else begin
            $display("ok   miss: rtc=%0d", rtc_cur);
          end
        end
      end
    end
  end

  initial begin : stim
    longint r0;
    longint tg;
    int     tns;
    rst            = 1'b1;
    time_reg_ns    = '0;
    time_reg_sec   = '0;
    trig_ld        = 1'b0;
    trig_sec_in    = '0;
    trig_ns_in     = '0;
    trig_width_in  = '0;
    trig_period_in = '0;
    trig_cancel    = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("reset", {trig_out, trig_armed, trig_missed, trig_done}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    // Target 11.000 from 10.900, width 4: fires after RTC reads 11.004.
    scenario("fire_w4", 10900, 11, 0, 4, 0, 40, 1'b0);
    // Target already passed on arming.
    scenario("late", 10900, 10, 100, 3, 0, 10, 1'b0);
    // Period 200, width 2: six pulses through the 12.000 carry when periodic.
    scenario("periodic", 10900, 11, 0, 2, 200, 160, 1'b0);
    // Cancel during the second pulse cycle: two cycles, no done.
    scenario("cancel_p2", 10900, 11, 0, 4, 0, 16, 1'b0);
    // Reset during the pulse, then nothing fires afterwards.
    scenario("rst_pulse", 10900, 11, 0, 4, 0, 15, 1'b1);
    // Out-of-range ns clamps to 10.999; width 0 behaves as 1.
    scenario("clamp_w0", 10900, 10, 1023, 0, 0, 30, 1'b0);

    // Load and cancel in the same cycle: load wins.
    trig_sec_in = 48'd30; trig_ns_in = 30'd0; trig_width_in = 32'd2; trig_period_in = 30'd0;
    drive(20000, 1'b1, 1'b1);
    @(posedge clk);
    #3;
    check("ld_cancel", {trig_out, trig_armed, trig_missed, trig_done}, 4'b0100);
    drive(20008, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    check("ld_cancel_idle", {trig_out, trig_armed, trig_missed, trig_done}, 4'b0000);

    for (int n = 0; n < 40; n++) begin
      r0  = 10000 + longint'($urandom_range(0, 999));
      tg  = r0 + longint'($urandom_range(0, 700)) - 150;
      tns = int'(tg % NS_WRAP);
      if ($urandom_range(0, 7) == 0) tns = int'($urandom_range(1000, 1023));
      scenario("rand", r0, tg / NS_WRAP, tns, int'($urandom_range(0, 5)),
               ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(30, 250)),
               int'($urandom_range(10, 150)), $urandom_range(0, 4) == 0);
    end

    repeat (3) @(posedge clk);
    #4;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL events_left: %0d expected events never seen, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
